// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_pkg
// Purpose  : Shared types and constants for the USB transmit scheduler:
//            handshake PIDs, FSM state encoding, grant-type encoding.
// Revision : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    PID  = 3'd2,
    DATA = 3'd3,
    EOP  = 3'd4,
    GAP  = 3'd5
  } tx_state_t;

  // Encoding order mirrors arbitration priority, highest first.
  typedef enum logic [1:0] {
    G_STALL = 2'd0,
    G_NAK   = 2'd1,
    G_ACK   = 2'd2,
    G_DATA  = 2'd3
  } grant_t;

  // PID byte to serialise for a given grant type.
  function automatic logic [7:0] grant_pid(input grant_t g, input logic [7:0] data_pid);
    case (g)
      G_STALL: grant_pid = PID_STALL;
      G_NAK:   grant_pid = PID_NAK;
      G_ACK:   grant_pid = PID_ACK;
      default: grant_pid = data_pid;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler_if
// Purpose  : Request/stream/line signals between the packet sources, the
//            TX scheduler and the downstream NRZI/line driver.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_tx_scheduler_if;
  logic       checkData;
  logic       reqAck;
  logic       reqNak;
  logic       reqStall;
  logic       reqData;
  logic [7:0] dataPid;
  logic       dataBit;
  logic       dataLast;
  logic       txBit;
  logic       OE;
  logic       callEop;
  logic       dataGrant;
  logic       dataNext;
  logic       busy;
  logic       respDone;

  // Environment side: sources and line driver.
  modport master (
    output checkData, reqAck, reqNak, reqStall, reqData, dataPid, dataBit, dataLast,
    input  txBit, OE, callEop, dataGrant, dataNext, busy, respDone
  );

  // Scheduler side.
  modport slave (
    input  checkData, reqAck, reqNak, reqStall, reqData, dataPid, dataBit, dataLast,
    output txBit, OE, callEop, dataGrant, dataNext, busy, respDone
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_shift8.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_shift8
// Purpose  : 8-bit parallel-load register shifted out LSB first; carries
//            the PID byte onto the serial line.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_shift8 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_load,
  input  wire logic [7:0] i_data,
  input  wire logic       i_shift,
  output wire logic       o_lsb
);

  logic [7:0] r_q;

  // Load has precedence; shifting right exposes the next bit at r_q[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 8'h00;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[7:1]};
    end
  end

  assign o_lsb = r_q[0];

endmodule
`default_nettype wire

// File: rtl/usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler
// Purpose  : Owns the USB serial TX path. Arbitrates STALL > NAK > ACK >
//            DATA and emits SYNC, PID, optional payload and EOP one bit per
//            checkData strobe.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 8,
  parameter int unsigned EOP_LEN  = 3,
  parameter int unsigned GAP_LEN  = 2
) (
  input wire logic           useClk,
  input wire logic           reset,
  usb_tx_scheduler_if.slave  bus
);

  // Field lengths must fit the 4-bit bit counter.
  generate
    if (SYNC_LEN < 1 || SYNC_LEN > 15 || EOP_LEN < 1 || EOP_LEN > 15 || GAP_LEN > 15) begin : g_param_check
      $error("usb_tx_scheduler: SYNC_LEN and EOP_LEN must be 1..15, GAP_LEN 0..15");
    end
  endgenerate

  // Counter value on the last bit time of each timed field.
  localparam logic [3:0] C_SYNC_LAST = 4'(SYNC_LEN - 1);
  localparam logic [3:0] C_EOP_LAST  = 4'(EOP_LEN - 1);
  localparam logic [3:0] C_GAP_LAST  = 4'(GAP_LEN - 1);
  localparam logic [3:0] C_PID_LAST  = 4'd7;

  // State holds the field whose bit is currently on the line; r_cnt is the
  // index of that bit within the field.
  tx_state_t  r_state;
  logic [3:0] r_cnt;
  grant_t     r_gtype;
  logic       r_last;
  logic       r_pend_ack;
  logic       r_pend_nak;
  logic       r_pend_stall;
  logic       r_tx_bit;
  logic       r_oe;
  logic       r_call_eop;
  logic       r_data_grant;
  logic       r_data_next;
  logic       r_resp_done;

  grant_t     w_gtype;
  logic       w_any;
  logic       w_slot;
  logic       w_grant;
  logic [7:0] w_pid;
  logic       w_shift;
  logic       w_pid_bit;

  // Arbitration, grant qualification and PID shifter control.
  always_comb begin
    w_gtype = G_DATA;
    if (r_pend_stall) begin
      w_gtype = G_STALL;
    end else if (r_pend_nak) begin
      w_gtype = G_NAK;
    end else if (r_pend_ack) begin
      w_gtype = G_ACK;
    end
    w_any   = r_pend_stall | r_pend_nak | r_pend_ack | bus.reqData;
    // The last gap bit time grants directly so the gap is exactly GAP_LEN.
    w_slot  = (r_state == IDLE) || ((r_state == GAP) && (r_cnt == C_GAP_LAST));
    w_grant = bus.checkData & w_any & w_slot;
    w_pid   = grant_pid(w_gtype, bus.dataPid);
    w_shift = bus.checkData &
              (((r_state == SYNC) && (r_cnt == C_SYNC_LAST)) ||
               ((r_state == PID)  && (r_cnt != C_PID_LAST)));
  end

  usb_tx_shift8 u_pid_shift (
    .clk     (useClk),
    .rst     (reset),
    .i_load  (w_grant),
    .i_data  (w_pid),
    .i_shift (w_shift),
    .o_lsb   (w_pid_bit)
  );

  // Sticky request flags, latched every clock; a request arriving on its own
  // grant clock survives the clear and is served again.
  always_ff @(posedge useClk or posedge reset) begin
    if (reset) begin
      r_pend_ack   <= 1'b0;
      r_pend_nak   <= 1'b0;
      r_pend_stall <= 1'b0;
    end else begin
      r_pend_stall <= (r_pend_stall & ~(w_grant & (w_gtype == G_STALL))) | bus.reqStall;
      r_pend_nak   <= (r_pend_nak   & ~(w_grant & (w_gtype == G_NAK)))   | bus.reqNak;
      r_pend_ack   <= (r_pend_ack   & ~(w_grant & (w_gtype == G_ACK)))   | bus.reqAck;
    end
  end

  // Packet sequencer with registered line outputs, stepping once per strobe.
  always_ff @(posedge useClk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_gtype      <= G_STALL;
      r_last       <= 1'b0;
      r_tx_bit     <= 1'b0;
      r_oe         <= 1'b0;
      r_call_eop   <= 1'b0;
      r_data_grant <= 1'b0;
      r_data_next  <= 1'b0;
      r_resp_done  <= 1'b0;
    end else begin
      r_data_next <= 1'b0;
      r_resp_done <= 1'b0;
      if (bus.checkData) begin
        if (w_grant) begin
          // First SYNC bit goes out on the grant strobe itself.
          r_state      <= SYNC;
          r_cnt        <= 4'd0;
          r_gtype      <= w_gtype;
          r_last       <= 1'b0;
          r_oe         <= 1'b1;
          r_call_eop   <= 1'b0;
          r_tx_bit     <= (C_SYNC_LAST == 4'd0);
          r_data_grant <= (w_gtype == G_DATA);
        end else begin
          case (r_state)
            IDLE: begin
              r_cnt <= 4'd0;
            end
            SYNC: begin
              if (r_cnt == C_SYNC_LAST) begin
                r_state  <= PID;
                r_cnt    <= 4'd0;
                r_tx_bit <= w_pid_bit;
              end else begin
                r_cnt    <= r_cnt + 4'd1;
                r_tx_bit <= ((r_cnt + 4'd1) == C_SYNC_LAST);
              end
            end
            PID: begin
              if (r_cnt == C_PID_LAST) begin
                r_cnt <= 4'd0;
                if ((r_gtype == G_DATA) && bus.reqData) begin
                  r_state     <= DATA;
                  r_tx_bit    <= bus.dataBit;
                  r_data_next <= 1'b1;
                  r_last      <= bus.dataLast;
                end else begin
                  r_state      <= EOP;
                  r_tx_bit     <= 1'b0;
                  r_call_eop   <= 1'b1;
                  r_data_grant <= 1'b0;
                end
              end else begin
                r_cnt    <= r_cnt + 4'd1;
                r_tx_bit <= w_pid_bit;
              end
            end
            DATA: begin
              // Payload length is set by the source, so no bit counting here.
              if (r_last || !bus.reqData) begin
                r_state      <= EOP;
                r_cnt        <= 4'd0;
                r_tx_bit     <= 1'b0;
                r_call_eop   <= 1'b1;
                r_data_grant <= 1'b0;
              end else begin
                r_tx_bit    <= bus.dataBit;
                r_data_next <= 1'b1;
                r_last      <= bus.dataLast;
              end
            end
            EOP: begin
              if (r_cnt == C_EOP_LAST) begin
                r_state      <= (GAP_LEN == 0) ? IDLE : GAP;
                r_cnt        <= 4'd0;
                r_oe         <= 1'b0;
                r_call_eop   <= 1'b0;
                r_tx_bit     <= 1'b0;
                r_data_grant <= 1'b0;
                r_resp_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            GAP: begin
              if (r_cnt == C_GAP_LAST) begin
                r_state <= IDLE;
                r_cnt   <= 4'd0;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            default: begin
              r_state <= IDLE;
              r_cnt   <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  assign bus.txBit     = r_tx_bit;
  assign bus.OE        = r_oe;
  assign bus.callEop   = r_call_eop;
  assign bus.dataGrant = r_data_grant;
  assign bus.dataNext  = r_data_next;
  assign bus.respDone  = r_resp_done;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire
